// File: rtl/uart_ascii_pkg.sv
// Shared types and constants for the UART ASCII receiver.
// UART_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_ascii_pkg;

  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;

  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1, tick on the wrap cycle.
// Sync clear realigns the phase to an external event.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_ascii_rx.sv
// UART receiver that keeps only printable ASCII and holds the last one.
// Define UART_PARITY_EN for 8E1 framing with even-parity checking.
module uart_ascii_rx
  import uart_ascii_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 100000000,
  parameter int         BAUD        = 115200,
  parameter int         OVERSAMPLE  = 16,
  parameter logic [7:0] RESET_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] ascii_value,
  output logic       ascii_valid,
  output logic       frame_err
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SUB_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);

  logic            r_sync1;
  logic            r_sync2;
  rx_state_t       r_state;
  logic [SW-1:0]   r_sub;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_value;
  logic            r_valid;
  logic            r_err;

  rx_state_t       w_state_nx;
  logic [SW-1:0]   w_sub_nx;
  logic [2:0]      w_bit_nx;
  logic [7:0]      w_shift_nx;
  logic            w_clr;
  logic            w_tick;
  logic            w_emit;
  logic            w_err;
  logic            w_rx;
  logic            w_print;

`ifdef UART_PARITY_EN
  logic            r_par_fail;
  logic            w_par_fail_nx;
`endif

  assign w_rx    = r_sync2;
  assign w_print = (r_shift >= ASCII_MIN) && (r_shift <= ASCII_MAX);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nx = r_state;
    w_sub_nx   = r_sub;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_clr      = 1'b0;
    w_emit     = 1'b0;
    w_err      = 1'b0;
`ifdef UART_PARITY_EN
    w_par_fail_nx = r_par_fail;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state_nx = S_START;
          w_clr      = 1'b1;
          w_sub_nx   = '0;
`ifdef UART_PARITY_EN
          w_par_fail_nx = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          w_sub_nx = r_sub + 1'b1;
          if (r_sub == SUB_MID) begin
            w_sub_nx   = '0;
            w_bit_nx   = '0;
            w_state_nx = w_rx ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_sub_nx = r_sub + 1'b1;
          if (r_sub == SUB_LAST) begin
            w_shift_nx = {w_rx, r_shift[7:1]};
            w_bit_nx   = r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              w_state_nx = S_PARITY;
`else
              w_state_nx = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_sub_nx = r_sub + 1'b1;
          if (r_sub == SUB_LAST) begin
            w_par_fail_nx = ^{r_shift, w_rx};
            w_state_nx    = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_sub_nx = r_sub + 1'b1;
          if (r_sub == SUB_LAST) begin
            if (!w_rx) begin
              w_err      = 1'b1;
              w_state_nx = S_WAIT_IDLE;
`ifdef UART_PARITY_EN
            end else if (r_par_fail) begin
              w_err      = 1'b1;
              w_state_nx = S_IDLE;
`endif
            end else begin
              w_emit     = w_print;
              w_state_nx = S_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_rx) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_sub   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_value <= RESET_CHAR;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nx;
      r_sub   <= w_sub_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_valid <= w_emit;
      r_err   <= w_err;
      if (w_emit) begin
        r_value <= r_shift;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_fail <= 1'b0;
    end else begin
      r_par_fail <= w_par_fail_nx;
    end
  end
`endif

  assign ascii_value = r_value;
  assign ascii_valid = r_valid;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Directed bench for uart_ascii_rx at 100 MHz / 115200 baud, 8N1.
// A frame-level model predicts each pulse and the held character.
module tb_uart_ascii_rx;

  localparam int BIT = 864;
  localparam int LAT = 8211;
  localparam int TOL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] ascii_value;
  logic       ascii_valid;
  logic       frame_err;

  typedef struct {
    logic [7:0] ch;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         err_q[$];
  logic [7:0] model_val = 8'h20;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  uart_ascii_rx dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .ascii_value (ascii_value),
    .ascii_valid (ascii_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (ascii_valid && frame_err) begin
        n_fail++;
        $display("FAIL both_high cyc=%0d got valid=1 err=1 want not both", cyc);
      end
      if (ascii_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_valid cyc=%0d got value=%h want no pulse",
                   cyc, ascii_value);
        end else begin
          exp_t e;
          int d;
          e = exp_q.pop_front();
          d = cyc - e.due;
          n_chk++;
          if (ascii_value !== e.ch) begin
            n_fail++;
            $display("FAIL valid_value cyc=%0d got %h want %h",
                     cyc, ascii_value, e.ch);
          end
          n_chk++;
          if (d < -TOL || d > TOL) begin
            n_fail++;
            $display("FAIL valid_time got cyc=%0d want %0d", cyc, e.due);
          end
          model_val = e.ch;
        end
      end else if (ascii_value !== model_val) begin
        n_fail++;
        $display("FAIL held_value cyc=%0d got %h want %h",
                 cyc, ascii_value, model_val);
      end
      if (frame_err) begin
        n_chk++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_err cyc=%0d got 1 want 0", cyc);
        end else begin
          int due;
          due = err_q.pop_front();
          if (cyc - due < -TOL || cyc - due > TOL) begin
            n_fail++;
            $display("FAIL err_time got cyc=%0d want %0d", cyc, due);
          end
        end
      end
      if (exp_q.size() != 0 && cyc > exp_q[0].due + TOL) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_valid cyc=%0d got none want %h",
                 cyc, exp_q[0].ch);
        void'(exp_q.pop_front());
      end
      if (err_q.size() != 0 && cyc > err_q[0] + TOL) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_err cyc=%0d got none want pulse", cyc);
        void'(err_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    int c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    if (!stop) begin
      err_q.push_back(c0 + LAT);
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back('{ch: b, due: c0 + LAT});
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic check8(input string name, input logic [7:0] act,
                        input logic [7:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic check1(input string name, input logic act,
                        input logic want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %b want %b", name, act, want);
    end
  endtask

  initial begin
    logic [7:0] p;
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check8("rst_value", ascii_value, 8'h20);
    check1("rst_valid", ascii_valid, 1'b0);
    check1("rst_err", frame_err, 1'b0);
    #1;
    rst = 1'b0;
    model_val = 8'h20;
    idle(10000);
    @(negedge clk);
    check8("idle_value", ascii_value, 8'h20);

    send_byte(8'h34, 1'b1);
    idle(100);
    @(negedge clk);
    check8("char_4", ascii_value, 8'h34);

    send_byte(8'h21, 1'b1);
    send_byte(8'h43, 1'b1);
    idle(100);
    @(negedge clk);
    check8("char_C", ascii_value, 8'h43);

    send_byte(8'h0D, 1'b1);
    idle(100);
    @(negedge clk);
    check8("cr_dropped", ascii_value, 8'h43);

    send_byte(8'h41, 1'b0);
    uart_rx = 1'b0;
    idle(2 * BIT);
    uart_rx = 1'b1;
    idle(100);
    @(negedge clk);
    check8("err_held", ascii_value, 8'h43);
    send_byte(8'h42, 1'b1);
    idle(100);
    @(negedge clk);
    check8("char_B", ascii_value, 8'h42);

    #1;
    uart_rx = 1'b0;
    idle(300);
    uart_rx = 1'b1;
    idle(1000);
    @(negedge clk);
    check8("glitch_held", ascii_value, 8'h42);

    p = 8'h55;
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(p[i]);
    uart_rx = p[3];
    idle(BIT / 2);
    rst = 1'b1;
    uart_rx = 1'b1;
    model_val = 8'h20;
    idle(5);
    rst = 1'b0;
    idle(200);
    @(negedge clk);
    check8("midrst_value", ascii_value, 8'h20);
    send_byte(8'h5A, 1'b1);
    idle(100);
    @(negedge clk);
    check8("char_Z", ascii_value, 8'h5A);

    n_chk++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover got %0d/%0d pending want 0/0",
               exp_q.size(), err_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_ascii_rx.md
Name: uart_ascii_rx

Overview:
Serial character source for font_read_top. Receives 8N1 UART bytes from the host on uart_rx, filters them to printable ASCII, and presents the last accepted character on ascii_value, a held register that drives font_read_top.ascii_value directly. A one-cycle ascii_valid strobe marks each update. frame_err flags malformed frames.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency (10 ns period)
BAUD, 115200, line rate
OVERSAMPLE, 16, baud ticks per bit; must be a power of 2 and at least 8
RESET_CHAR, 8'h20, ascii_value after reset (space)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial line, idle high
ascii_value  output  8  last accepted printable character, held until the next one
ascii_valid  output  1  one-cycle pulse in the cycle ascii_value updates
frame_err  output  1  one-cycle pulse on a stop-bit or parity error

Behaviour:
- Reset (rst=1 at a clk edge):
  - ascii_value=RESET_CHAR, ascii_valid=0, frame_err=0.
  - FSM=IDLE; tick counter, bit counter and shift register cleared.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame; nothing is emitted.
- Input synchronization:
  - uart_rx passes through a 2-flop synchronizer, giving rx_s.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- Baud tick:
  - DIV = CLK_FREQ_HZ/(BAUD*OVERSAMPLE), integer truncation; 54 at defaults.
  - The tick counter counts 0..DIV-1 and pulses tick on wrap.
  - The counter restarts at 0 on entry to START so that bit sampling is phase-aligned.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, WAIT_IDLE.
  - IDLE: rx_s==0 moves to START with sub-tick counter cleared.
  - START: at sub-tick OVERSAMPLE/2-1 (mid start bit), rx_s==1 is a false start and returns to IDLE with no flags; rx_s==0 moves to DATA, sub-tick cleared.
  - DATA: every OVERSAMPLE ticks, sample rx_s into an 8-bit shift register, LSB first. After bit 7, move to PARITY if the feature is enabled, otherwise to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s==1 with a printable byte (8'h20..8'h7E inclusive): ascii_value<=byte and ascii_valid=1 in that same cycle. Return to IDLE.
    - rx_s==1 with a non-printable byte: silently dropped, no pulse, ascii_value held. Return to IDLE.
    - rx_s==0: frame_err=1, ascii_value held, move to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 (break or line-low handling), then move to IDLE.
- Latency: ascii_valid rises in the first clk after the mid-stop-bit sample, about 9.5 bit times after the start-bit falling edge plus 2 synchronizer cycles.
- Boundary conditions:
  - ascii_valid and frame_err are never high together.
  - A new start edge during STOP cannot be seen before the stop sample.
  - Back-to-back frames with a single stop bit must all be received.
  - Baud error tolerance is ±3%.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - The frame is 8E1. PARITY is sampled one bit time after bit 7.
  - If the XOR of the 8 data bits and the parity bit is 1, set a parity-fail flag. At the stop sample this gives frame_err=1 and the byte is discarded.
  - After a parity failure, return to IDLE if the stop bit is good, or to WAIT_IDLE if it is bad.
- Undefined: the PARITY state and its logic are absent; the frame is 8N1.

Decomposition:
- Package uart_ascii_pkg holds:
  - The state enum.
  - Constants ASCII_MIN=8'h20 and ASCII_MAX=8'h7E.
  - A function computing DIV from CLK_FREQ_HZ, BAUD and OVERSAMPLE.
- One sub-module, uart_baud_tick: parameterised divider with a sync clear input and a tick output, reusable by a future TX block.

Test Plan:
- Reset held 50 cycles, then released with uart_rx=1 → ascii_value=8'h20; ascii_valid and frame_err stay 0 for 10000 cycles.
- Send 8'h34 ("4") at 115200 (bit = 864 clk) → exactly one ascii_valid pulse about 8210 cycles after the start edge; ascii_value=8'h34 and held afterwards.
- Send "!" then "C" back-to-back → two pulses; ascii_value goes 8'h21 then 8'h43.
- Send 8'h0D → no ascii_valid, no frame_err, ascii_value unchanged.
- Send 8'h41 with stop bit=0, line held low 3 bit times → one frame_err pulse, ascii_value unchanged. A following 8'h42 is received correctly.
- 300-cycle low glitch on idle line → false start; no pulses. Also: assert rst mid-DATA of a frame → no pulse, ascii_value=8'h20, next frame received correctly.
